seq_shifter: RTL and testbench

Parametrised multi-cycle barrel-shift replacement for the DispositivosInOut datapath. It accepts an operand, shift amount and mode on a one-cycle start strobe, then shifts one bit position per clock. On completion it presents the result with carry and zero flags and a one-cycle done pulse. It replaces the fixed 16-bit, two-direction shifter and adds arithmetic and rotate modes, a start/busy/done handshake and a well-defined reset.

---
 rtl/seq_shifter.sv | 129 ++++++++++++
 tb/tb_seq_shifter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter, one bit position per clock.
// Supports SLL, SRL, SRA and ROR with a start/busy/done handshake;
// result, carry and zero are registered and held between completions.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value_in,
  input  logic [AMT_W-1:0] amount_in,
  input  logic [1:0]       mode_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } mode_t;

  state_t           state_q,  state_d;
  mode_t            mode_q,   mode_d;
  logic [WIDTH-1:0] work_q,   work_d;
  logic [AMT_W-1:0] cnt_q,    cnt_d;
  logic             cwork_q,  cwork_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q,  carry_d;
  logic             zero_q,   zero_d;
  logic             done_q,   done_d;

  // Next-state: load on start in IDLE, one shift step per SHIFT cycle, publish when count exhausted
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    cwork_d  = cwork_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = value_in;
          cnt_d   = amount_in;
          mode_d  = mode_t'(mode_in);
          cwork_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - AMT_W'(1);
          unique case (mode_q)
            MODE_SLL: begin
              work_d  = {work_q[WIDTH-2:0], 1'b0};
              cwork_d = work_q[WIDTH-1];
            end
            MODE_SRL: begin
              work_d  = {1'b0, work_q[WIDTH-1:1]};
              cwork_d = work_q[0];
            end
            MODE_SRA: begin
              work_d  = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
              cwork_d = work_q[0];
            end
            MODE_ROR: begin
              work_d  = {work_q[0], work_q[WIDTH-1:1]};
              cwork_d = work_q[0];
            end
            default: ;
          endcase
        end else begin
          result_d = work_q;
          carry_d  = cwork_q;
          zero_d   = (work_q == '0);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; synchronous reset aborts any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= MODE_SLL;
      work_q   <= '0;
      cnt_q    <= '0;
      cwork_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      cwork_q  <= cwork_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Testbench for seq_shifter: directed handshake/boundary steps plus random
// sweeps on a 16-bit (5-bit amount) and an 8-bit (4-bit amount) instance.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start16 = 1'b0;
  logic [15:0] value16 = '0;
  logic [4:0]  amount16 = '0;
  logic [1:0]  mode16 = '0;
  logic        busy16, done16, carry16, zero16;
  logic [15:0] result16;

  logic        start8 = 1'b0;
  logic [7:0]  value8 = '0;
  logic [3:0]  amount8 = '0;
  logic [1:0]  mode8 = '0;
  logic        busy8, done8, carry8, zero8;
  logic [7:0]  result8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16), .AMT_W(5)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .value_in(value16),
    .amount_in(amount16), .mode_in(mode16), .busy(busy16), .done(done16),
    .result(result16), .carry(carry16), .zero(zero16)
  );

  seq_shifter #(.WIDTH(8), .AMT_W(4)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .value_in(value8),
    .amount_in(amount8), .mode_in(mode8), .busy(busy8), .done(done8),
    .result(result8), .carry(carry8), .zero(zero8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: closed-form shift of a w-bit value by amt with the given mode
  function automatic void ref_shift(input logic [31:0] v, input int amt, input int m,
                                    input int w, output logic [31:0] r, output logic c);
    logic [63:0]        mask;
    logic [63:0]        vv;
    logic signed [63:0] s;
    int                 k;
    mask = (64'd1 << w) - 64'd1;
    vv   = {32'd0, v} & mask;
    case (m)
      0: begin
        r = 32'((vv << amt) & mask);
        c = (amt == 0 || amt > w) ? 1'b0 : vv[w - amt];
      end
      1: begin
        r = 32'(vv >> amt);
        c = (amt == 0 || amt > w) ? 1'b0 : vv[amt - 1];
      end
      2: begin
        s = vv[w-1] ? signed'(vv | ~mask) : signed'(vv);
        r = 32'((s >>> amt) & mask);
        c = (amt == 0) ? 1'b0 : (amt <= w) ? vv[amt - 1] : vv[w-1];
      end
      default: begin
        k = amt % w;
        r = 32'(((vv >> k) | (vv << (w - k))) & mask);
        c = (amt == 0) ? 1'b0 : vv[(amt - 1) % w];
      end
    endcase
  endfunction

  // Present a request on the 16-bit instance and step past its accepting edge
  task automatic go16(input logic [15:0] v, input int a, input int m);
    start16 = 1'b1; value16 = v; amount16 = 5'(a); mode16 = 2'(m);
    @(posedge clk); #1;
    start16 = 1'b0;
    check("busy16_accept", 32'(busy16), 32'd1);
  endtask

  // Count edges until done, checking busy stays high until then
  task automatic wait16(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!done16) check("busy16_hold", 32'(busy16), 32'd1);
    end while (!done16 && n < 64);
    check("done16_seen", 32'(done16), 32'd1);
    check("busy16_at_done", 32'(busy16), 32'd0);
  endtask

  task automatic run16(input logic [15:0] v, input int a, input int m);
    logic [31:0] er;
    logic        ec;
    int          n;
    ref_shift(32'(v), a, m, 16, er, ec);
    go16(v, a, m);
    wait16(n);
    check("latency16", 32'(n), 32'(a + 1));
    check("result16", 32'(result16), er);
    check("carry16", 32'(carry16), 32'(ec));
    check("zero16", 32'(zero16), 32'(er == 0));
  endtask

  task automatic run8(input logic [7:0] v, input int a, input int m);
    logic [31:0] er;
    logic        ec;
    int          n;
    ref_shift(32'(v), a, m, 8, er, ec);
    start8 = 1'b1; value8 = v; amount8 = 4'(a); mode8 = 2'(m);
    @(posedge clk); #1;
    start8 = 1'b0;
    check("busy8_accept", 32'(busy8), 32'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done8 && n < 64);
    check("latency8", 32'(n), 32'(a + 1));
    check("result8", 32'(result8), er);
    check("carry8", 32'(carry8), 32'(ec));
    check("zero8", 32'(zero8), 32'(er == 0));
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy16), 32'd0);
    check("rst_done", 32'(done16), 32'd0);
    check("rst_result", 32'(result16), 32'd0);
    check("rst_carry", 32'(carry16), 32'd0);
    check("rst_zero", 32'(zero16), 32'd0);
    check("rst_result8", 32'(result8), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed values with literal expectations
    run16(16'h0001, 4, 0);
    check("sll4_const", 32'(result16), 32'h0010);
    run16(16'h8000, 3, 2);
    check("sra3_const", 32'(result16), 32'hF000);
    run16(16'h8000, 3, 1);
    check("srl3_const", 32'(result16), 32'h1000);
    run16(16'h0001, 1, 3);
    check("ror1_const", 32'(result16), 32'h8000);
    check("ror1_carry", 32'(carry16), 32'd1);
    for (int m = 0; m < 4; m++) begin
      run16(16'hA5A5, 0, m);
      check("amt0_const", 32'(result16), 32'hA5A5);
    end
    run16(16'h0003, 15, 0);
    check("sll15_const", 32'(result16), 32'h8000);
    check("sll15_carry", 32'(carry16), 32'd1);
    run16(16'h0001, 1, 1);
    check("srl1_zero", 32'(zero16), 32'd1);
    check("srl1_carry", 32'(carry16), 32'd1);

    // Amounts beyond WIDTH are iterated literally
    run16(16'h1234, 17, 3);
    check("ror17_const", 32'(result16), 32'h091A);
    run16(16'hFFFF, 20, 0);
    run16(16'h8001, 31, 2);
    check("sra31_const", 32'(result16), 32'hFFFF);

    // Start while busy is ignored
    go16(16'h0001, 8, 0);
    start16 = 1'b1; value16 = 16'hFFFF; amount16 = 5'd3; mode16 = 2'd1;
    @(posedge clk); #1;
    start16 = 1'b0;
    check("busy16_ignore", 32'(busy16), 32'd1);
    wait16(n);
    check("ignore_latency", 32'(n + 1), 32'd9);
    check("ignore_result", 32'(result16), 32'h0100);
    // Start in the done cycle is accepted
    check("done_cycle", 32'(done16), 32'd1);
    run16(16'h00F0, 2, 1);
    check("b2b_result", 32'(result16), 32'h003C);

    // Reset in flight aborts without done
    go16(16'h1234, 10, 0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy16), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy16), 32'd0);
    check("abort_done", 32'(done16), 32'd0);
    check("abort_result", 32'(result16), 32'd0);
    check("abort_carry", 32'(carry16), 32'd0);
    check("abort_zero", 32'(zero16), 32'd0);
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done16) n++;
    end
    check("abort_no_done", 32'(n), 32'd0);
    run16(16'h4321, 5, 3);

    // Random sweeps on both widths
    repeat (80) run16(16'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
    repeat (80) run8(8'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
